cla_subtractor_pipelined: RTL and testbench

// - Pipelined two's-complement subtractor (diff = a - b - borrow_in) built from 4-bit carry-lookahead groups.
// - One group per pipeline stage; group carry is registered between stages; valid/ready handshake both ends.
// - Inverse-direction companion to the group CLA adder; sits in the datapath ALU as the SUB/CMP unit.

---
 rtl/cla_subtractor_pipelined_if.sv | 45 ++++
 rtl/cla_subtractor_pipelined.sv | 152 +++++++++++++++
 tb/tb_cla_subtractor_pipelined.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/cla_subtractor_pipelined_if.sv
`default_nettype none
// ============================================================================
// Module   : cla_subtractor_pipelined_if
// Purpose  : Operand/result handshake bundle for the pipelined CLA subtractor.
// Options  : ADD_MODE_EN adds the op_sub operation select.
// Revision : 1.0 - initial release
// ============================================================================
interface cla_subtractor_pipelined_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             borrow_in;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] diff;
   logic             borrow_out;
   logic             overflow;
`ifdef ADD_MODE_EN
   logic             op_sub;

   modport master (
      output in_valid, a, b, borrow_in, op_sub, out_ready,
      input  in_ready, out_valid, diff, borrow_out, overflow
   );

   modport slave (
      input  in_valid, a, b, borrow_in, op_sub, out_ready,
      output in_ready, out_valid, diff, borrow_out, overflow
   );
`else
   modport master (
      output in_valid, a, b, borrow_in, out_ready,
      input  in_ready, out_valid, diff, borrow_out, overflow
   );

   modport slave (
      input  in_valid, a, b, borrow_in, out_ready,
      output in_ready, out_valid, diff, borrow_out, overflow
   );
`endif
endinterface
`default_nettype wire

// File: rtl/cla_subtractor_pipelined.sv
`default_nettype none
// ============================================================================
// Module   : cla_subtractor_pipelined
// Purpose  : diff = a - b - borrow_in, one 4-bit carry-lookahead group per stage.
// Options  : ADD_MODE_EN adds op_sub (0 = a + b + borrow_in).
// Revision : 1.0 - initial release
// ============================================================================
module cla_subtractor_pipelined #(
   parameter int WIDTH = 16,
   parameter int GROUP = 4
) (
   input wire clk,
   input wire rst,
   cla_subtractor_pipelined_if.slave bus
);
   localparam int c_STAGES = WIDTH / GROUP;
   localparam int c_LAST   = c_STAGES - 1;

   logic                w_op_in;
   logic [c_STAGES:0]   w_ready;

   logic                w_src_valid [c_STAGES];
   logic [WIDTH-1:0]    w_src_res   [c_STAGES];
   logic [WIDTH-1:0]    w_src_bx    [c_STAGES];
   logic                w_src_cin   [c_STAGES];
   logic                w_src_op    [c_STAGES];

   logic [WIDTH-1:0]    w_nxt_res   [c_STAGES];
   logic [WIDTH-1:0]    w_nxt_bx    [c_STAGES];
   logic                w_nxt_carry [c_STAGES];
   logic                w_nxt_borrow;
   logic                w_nxt_ovf;

   logic [GROUP-1:0]    w_gen;
   logic [GROUP-1:0]    w_prop;
   logic [GROUP:0]      w_c;
   logic                w_term;

   // r_res: resolved diff bits below the current group, untouched minuend above.
   // r_bx : remaining effective subtrahend, shifted so the next group sits at bit 0.
   logic                r_valid [c_STAGES];
   logic [WIDTH-1:0]    r_res   [c_STAGES];
   logic [WIDTH-1:0]    r_bx    [c_STAGES];
   logic                r_carry [c_STAGES];
   logic                r_op    [c_STAGES];
   logic                r_borrow;
   logic                r_ovf;

`ifdef ADD_MODE_EN
   assign w_op_in = bus.op_sub;
`else
   assign w_op_in = 1'b1;
`endif

   always_comb begin
      w_ready           = '0;
      w_ready[c_STAGES] = bus.out_ready;
      for (int k = c_STAGES - 1; k >= 0; k--) begin
         w_ready[k] = ~r_valid[k] | w_ready[k+1];
      end
   end

   always_comb begin
      w_src_valid[0] = bus.in_valid;
      w_src_res[0]   = bus.a;
      w_src_bx[0]    = w_op_in ? ~bus.b : bus.b;
      w_src_cin[0]   = w_op_in ? ~bus.borrow_in : bus.borrow_in;
      w_src_op[0]    = w_op_in;
      for (int k = 1; k < c_STAGES; k++) begin
         w_src_valid[k] = r_valid[k-1];
         w_src_res[k]   = r_res[k-1];
         w_src_bx[k]    = r_bx[k-1];
         w_src_cin[k]   = r_carry[k-1];
         w_src_op[k]    = r_op[k-1];
      end
   end

   always_comb begin
      w_gen        = '0;
      w_prop       = '0;
      w_c          = '0;
      w_term       = 1'b0;
      w_nxt_borrow = 1'b0;
      w_nxt_ovf    = 1'b0;
      for (int k = 0; k < c_STAGES; k++) begin
         w_gen  = w_src_res[k][k*GROUP +: GROUP] & w_src_bx[k][GROUP-1:0];
         w_prop = w_src_res[k][k*GROUP +: GROUP] ^ w_src_bx[k][GROUP-1:0];
         // Flat lookahead: c[i] = OR_j (g[j] & p[j+1..i-1]) | (p[0..i-1] & cin)
         w_c    = '0;
         w_c[0] = w_src_cin[k];
         for (int i = 1; i <= GROUP; i++) begin
            w_c[i] = w_src_cin[k];
            for (int m = 0; m < i; m++) begin
               w_c[i] = w_c[i] & w_prop[m];
            end
            for (int j = 0; j < i; j++) begin
               w_term = w_gen[j];
               for (int m = j + 1; m < i; m++) begin
                  w_term = w_term & w_prop[m];
               end
               w_c[i] = w_c[i] | w_term;
            end
         end
         w_nxt_res[k]                    = w_src_res[k];
         w_nxt_res[k][k*GROUP +: GROUP]  = w_prop ^ w_c[GROUP-1:0];
         w_nxt_bx[k]                     = w_src_bx[k] >> GROUP;
         w_nxt_carry[k]                  = w_c[GROUP];
      end
      // Operands agreeing in sign (after inversion) but result sign differing.
      w_nxt_ovf    = ~(w_src_res[c_LAST][WIDTH-1] ^ w_src_bx[c_LAST][GROUP-1])
                   & (w_nxt_res[c_LAST][WIDTH-1] ^ w_src_res[c_LAST][WIDTH-1]);
      w_nxt_borrow = w_src_op[c_LAST] ? ~w_nxt_carry[c_LAST] : w_nxt_carry[c_LAST];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < c_STAGES; k++) begin
            r_valid[k] <= 1'b0;
            r_res[k]   <= '0;
            r_bx[k]    <= '0;
            r_carry[k] <= 1'b0;
            r_op[k]    <= 1'b0;
         end
         r_borrow <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         for (int k = 0; k < c_STAGES; k++) begin
            if (w_ready[k]) begin
               r_valid[k] <= w_src_valid[k];
               if (w_src_valid[k]) begin
                  r_res[k]   <= w_nxt_res[k];
                  r_bx[k]    <= w_nxt_bx[k];
                  r_carry[k] <= w_nxt_carry[k];
                  r_op[k]    <= w_src_op[k];
               end
            end
         end
         if (w_ready[c_LAST] && w_src_valid[c_LAST]) begin
            r_borrow <= w_nxt_borrow;
            r_ovf    <= w_nxt_ovf;
         end
      end
   end

   assign bus.in_ready   = w_ready[0];
   assign bus.out_valid  = r_valid[c_LAST];
   assign bus.diff       = r_res[c_LAST];
   assign bus.borrow_out = r_borrow;
   assign bus.overflow   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_cla_subtractor_pipelined.sv
`default_nettype none
// ============================================================================
// Module   : tb_cla_subtractor_pipelined
// Purpose  : Randomised and directed scoreboard bench for cla_subtractor_pipelined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cla_subtractor_pipelined;
   localparam int W      = 16;
   localparam int STAGES = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cla_subtractor_pipelined_if #(.WIDTH(W)) bus ();

   cla_subtractor_pipelined #(.WIDTH(W), .GROUP(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct packed {
      logic [W-1:0] diff;
      logic         borrow;
      logic         ovf;
      int           cyc;
      logic         chk_lat;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;
   logic lat_mode = 1'b0;
   logic saw_full = 1'b0;
   logic last_acc = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Plain-integer reference: unsigned borrow/carry and signed range test.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic bin, input logic op);
      exp_t       e;
      int         sa, sb, sr;
      logic [W:0] full;
      e  = '0;
      sa = $signed(a);
      sb = $signed(b);
      if (op) begin
         full     = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
         e.borrow = ({1'b0, a} < ({1'b0, b} + {{W{1'b0}}, bin}));
         sr       = sa - sb - (bin ? 1 : 0);
      end else begin
         full     = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, bin};
         e.borrow = full[W];
         sr       = sa + sb + (bin ? 1 : 0);
      end
      e.diff = full[W-1:0];
      e.ovf  = (sr > (2**(W-1)) - 1) || (sr < -(2**(W-1)));
      return e;
   endfunction

   task automatic step(input logic v, input logic [W-1:0] ta, input logic [W-1:0] tbv,
                       input logic bin, input logic op, input logic ordy);
      exp_t e;
      @(negedge clk);
      bus.in_valid  = v;
      bus.a         = ta;
      bus.b         = tbv;
      bus.borrow_in = bin;
      bus.out_ready = ordy;
`ifdef ADD_MODE_EN
      bus.op_sub    = op;
`endif
      #1;
      cyc++;
      check("in_ready", bus.in_ready, (q.size() < STAGES) || ordy);
      if (!bus.in_ready) saw_full = 1'b1;
      if (bus.out_valid) begin
         if (q.size() == 0) begin
            check("spurious_out_valid", bus.out_valid, 1'b0);
         end else begin
            check("diff", bus.diff, q[0].diff);
            check("borrow_out", bus.borrow_out, q[0].borrow);
            check("overflow", bus.overflow, q[0].ovf);
            if (ordy) begin
               if (q[0].chk_lat) check("latency", cyc - q[0].cyc, STAGES);
               void'(q.pop_front());
            end
         end
      end
      last_acc = v && bus.in_ready;
      if (last_acc) begin
         e         = model(ta, tbv, bin, op);
         e.cyc     = cyc;
         e.chk_lat = lat_mode;
         q.push_back(e);
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && q.size() != 0; i++) step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
      check("drain_empty", q.size(), 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      q.delete();
      #1;
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_in_ready", bus.in_ready, 1'b1);
   endtask

   function automatic logic [W-1:0] rnd_operand();
      case ($urandom % 8)
         0:       return 16'h0000;
         1:       return 16'hFFFF;
         2:       return 16'h8000;
         3:       return 16'h7FFF;
         default: return W'($urandom);
      endcase
   endfunction

   logic [W-1:0] sa_arr [8];
   logic [W-1:0] sb_arr [8];
   logic         sbin   [8];

   initial begin
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.borrow_in = 1'b0;
      bus.out_ready = 1'b1;
`ifdef ADD_MODE_EN
      bus.op_sub    = 1'b1;
`endif
      do_reset();
      check("rst_diff", bus.diff, 0);
      check("rst_borrow", bus.borrow_out, 1'b0);
      check("rst_overflow", bus.overflow, 1'b0);

      // Directed corner vectors, latency checked
      lat_mode = 1'b1;
      step(1'b1, 16'h1234, 16'h0234, 1'b0, 1'b1, 1'b1);
      step(1'b1, 16'h0000, 16'h0001, 1'b0, 1'b1, 1'b1);
      step(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1);
      step(1'b1, 16'h0005, 16'h0003, 1'b1, 1'b1, 1'b1);
`ifdef ADD_MODE_EN
      step(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
      step(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
`endif
      drain();
      lat_mode = 1'b0;

      // Back-to-back stream of 8 with a consumer stall, operands held until accepted
      for (int i = 0; i < 8; i++) begin
         sa_arr[i] = rnd_operand();
         sb_arr[i] = rnd_operand();
         sbin[i]   = 1'($urandom);
      end
      saw_full = 1'b0;
      begin
         int sent = 0;
         for (int t = 0; t < 40 && sent < 8; t++) begin
            step(1'b1, sa_arr[sent], sb_arr[sent], sbin[sent], 1'b1, !(t >= 3 && t <= 7));
            if (last_acc) sent++;
         end
         check("stream_sent", sent, 8);
      end
      check("stream_saw_full", saw_full, 1'b1);
      drain();

      // Reset with three tokens in flight
      for (int i = 0; i < 3; i++) step(1'b1, rnd_operand(), rnd_operand(), 1'b0, 1'b1, 1'b1);
      do_reset();
      for (int i = 0; i < 8; i++) begin
         step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
         check("post_rst_no_output", bus.out_valid, 1'b0);
      end

      // Random traffic with random back-pressure
      for (int i = 0; i < 400; i++) begin
         logic op;
`ifdef ADD_MODE_EN
         op = 1'($urandom);
`else
         op = 1'b1;
`endif
         step(($urandom % 4) != 0, rnd_operand(), rnd_operand(), 1'($urandom), op,
              ($urandom % 3) != 0);
      end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
`default_nettype wire
